// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package if_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         ir;
    } fetch_entry_t;

    // True when a word index addresses an existing ROM word.
    function automatic logic word_in_range(input logic [63:0] word_idx, input int rom_words);
        return (word_idx < 64'(rom_words));
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Circular FIFO with read/write pointers and an occupancy count; DEPTH need not be a power of 2.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? PW'(0) : p + PW'(1);
    endfunction

    // Qualify push/pop; a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        do_pop_s  = pop && (count_r != CW'(0));
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s) && !flush;
    end

    // Pointer and count state; flush empties the queue synchronously.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= nxt_ptr(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= nxt_ptr(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_data;
    end

    // Head entry and occupancy exposed from registered state.
    always_comb begin
        head_data = mem_r[rd_ptr_r];
        count     = count_r;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: ROM issue with credit/epoch tracking, redirect flush, sticky range/alignment fault.
// Optional IF_SINGLE_STEP_EN adds step_mode/step_pulse to gate each issue on a pulse. XLEN must equal if_pkg::XLEN_DEF.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter int              ROM_WORDS = 1024,
    parameter int              ROM_AW    = 10,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IF_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_pulse,
`endif
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pcplus,
    output logic              fault,
    output logic [XLEN-1:0]   fault_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] issued_pc_r;
    logic [XLEN-1:0] fault_pc_r;
    logic            inflight_r;
    logic            epoch_r;
    logic            issue_epoch_r;
    logic            fault_r;

    logic [CW-1:0]   count_s;
    logic [CW:0]     occupancy_s;
    logic            pc_ok_s;
    logic            step_ok_s;
    logic            issue_s;
    logic            fault_set_s;
    logic            push_s;
    logic            pop_s;
    logic            valid_s;
    fetch_entry_t    entry_in_s;
    fetch_entry_t    head_s;

    // Issue, fault and response qualification; credit counts buffered plus in-flight reads.
    always_comb begin
        occupancy_s = (CW+1)'(count_s) + (CW+1)'(inflight_r);
        pc_ok_s     = word_in_range(64'(pc_r[XLEN-1:2]), ROM_WORDS) && (pc_r[1:0] == 2'b00);
`ifdef IF_SINGLE_STEP_EN
        step_ok_s   = !step_mode || step_pulse;
`else
        step_ok_s   = 1'b1;
`endif
        issue_s     = !rst && !fault_r && !redirect_valid && (occupancy_s < (CW+1)'(DEPTH))
                      && pc_ok_s && step_ok_s;
        fault_set_s = !rst && !fault_r && !inflight_r && !redirect_valid && !pc_ok_s;
        // A stale-epoch response is dropped; a same-cycle redirect flushes inside the FIFO.
        push_s      = inflight_r && (issue_epoch_r == epoch_r);
        valid_s     = !rst && (count_s != CW'(0));
        pop_s       = valid_s && out_ready;
        entry_in_s.pc = issued_pc_r;
        entry_in_s.ir = rom_data;
    end

    // Fetch state: PC, in-flight tracking, epoch and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            issued_pc_r   <= XLEN'(0);
            inflight_r    <= 1'b0;
            epoch_r       <= 1'b0;
            issue_epoch_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_pc_r    <= XLEN'(0);
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                issued_pc_r   <= pc_r;
                issue_epoch_r <= epoch_r;
            end
            if (redirect_valid) begin
                pc_r       <= redirect_pc;
                epoch_r    <= ~epoch_r;
                fault_r    <= 1'b0;
                fault_pc_r <= XLEN'(0);
            end else begin
                if (issue_s) pc_r <= pc_r + XLEN'(4);
                if (fault_set_s) begin
                    fault_r    <= 1'b1;
                    fault_pc_r <= pc_r;
                end
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (entry_in_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    // Output drive.
    always_comb begin
        rom_en     = issue_s;
        rom_addr   = pc_r[ROM_AW+1:2];
        out_valid  = valid_s;
        out_ir     = head_s.ir;
        out_pc     = head_s.pc;
        out_pcplus = head_s.pc + XLEN'(4);
        fault      = fault_r;
        fault_pc   = fault_pc_r;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: cycle table for start-up/back-pressure plus redirect and fault sequences.
module tb_if_fetch_queue;

    localparam int ROM_WORDS = 32;
    localparam int ROM_AW    = 5;
    localparam int DEPTH     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [31:0]       out_pc;
    logic [31:0]       out_pcplus;
    logic              fault;
    logic [31:0]       fault_pc;
`ifdef IF_SINGLE_STEP_EN
    logic              step_mode;
    logic              step_pulse;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN      (32),
        .ROM_WORDS (ROM_WORDS),
        .ROM_AW    (ROM_AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IF_SINGLE_STEP_EN
        .step_mode      (step_mode),
        .step_pulse     (step_pulse),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ir         (out_ir),
        .out_pc         (out_pc),
        .out_pcplus     (out_pcplus),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    function automatic logic [31:0] exp_ir(input logic [31:0] pc);
        return 32'hC0DE_0000 | {2'b00, pc[31:2]};
    endfunction

    // Synchronous ROM model, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= exp_ir({{(30-ROM_AW){1'b0}}, rom_addr, 2'b00});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic en, input logic v, input logic [31:0] pc);
        vecs.push_back('{rst: r, rdy: rdy, exp_en: en, exp_valid: v, exp_pc: pc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          en_cnt;
        logic        seen;
        logic [31:0] last_pc;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
`ifdef IF_SINGLE_STEP_EN
        step_mode      = 1'b0;
        step_pulse     = 1'b0;
`endif

        // Start-up with ID always ready: issue from cycle 0, head from cycle 2.
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h4);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h8);
        // Restart with ID stalled for 10 cycles: four issues fill the FIFO, head 0 held.
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 4; i < 10; i++) add(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        // Release: drain in order while credit reopens.
        add(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h4);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h8);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'hC);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h10);

        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle();
            rst       = vecs[i].rst;
            out_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d rom_en", i), 32'(rom_en), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d fault", i), 32'(fault), 32'h0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d out_ir", i), out_ir, exp_ir(vecs[i].exp_pc));
                chk($sformatf("vec%0d out_pcplus", i), out_pcplus, vecs[i].exp_pc + 32'h4);
            end
        end

        // Redirect to 0x40 in the cycle right after the issue of 0x10.
        next_cycle(); rst = 1'b1; out_ready = 1'b1;
        next_cycle(); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rom_en && rom_addr == ROM_AW'(4)) seen = 1'b1;
            else next_cycle();
        end
        chk("issue_0x10_seen", 32'(seen), 32'h1);
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        chk("redir_cycle rom_en", 32'(rom_en), 32'h0);
        next_cycle(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("after_redir out_valid", 32'(out_valid), 32'h0);
        chk("after_redir rom_en", 32'(rom_en), 32'h1);
        chk("after_redir rom_addr", 32'(rom_addr), 32'h10);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("redir head seen", 32'(seen), 32'h1);
        chk("redir head pc", out_pc, 32'h40);
        chk("redir head ir", out_ir, exp_ir(32'h40));

        // Run off the end of the ROM: last entry 0x7C, then sticky fault at 0x80.
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h60;
        next_cycle(); redirect_valid = 1'b0;
        seen = 1'b0; last_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) last_pc = out_pc;
            if (fault) seen = 1'b1;
            else next_cycle();
        end
        chk("range fault seen", 32'(seen), 32'h1);
        chk("range fault_pc", fault_pc, 32'h80);
        chk("range last pc", last_pc, 32'h7C);
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            @(negedge clk);
            if (rom_en) en_cnt++;
        end
        chk("range no issue", 32'(en_cnt), 32'h0);
        chk("range fault sticky", 32'(fault), 32'h1);
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h0;
        next_cycle(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir clears fault", 32'(fault), 32'h0);
        chk("redir clears fault_pc", fault_pc, 32'h0);
        chk("restart rom_en", 32'(rom_en), 32'h1);
        chk("restart rom_addr", 32'(rom_addr), 32'h0);

        // Misaligned redirect target.
        next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h6;
        next_cycle(); redirect_valid = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rom_en) en_cnt++;
            next_cycle();
        end
        @(negedge clk);
        chk("misalign no issue", 32'(en_cnt), 32'h0);
        chk("misalign fault", 32'(fault), 32'h1);
        chk("misalign fault_pc", fault_pc, 32'h6);
        chk("misalign drained", 32'(out_valid), 32'h0);
        next_cycle(); rst = 1'b1;
        @(negedge clk);
        chk("rst rom_en", 32'(rom_en), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk("rst clears fault", 32'(fault), 32'h0);
        chk("rst rom_en resume", 32'(rom_en), 32'h1);
        chk("rst rom_addr", 32'(rom_addr), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            next_cycle();
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst head seen", 32'(seen), 32'h1);
        chk("rst head pc", out_pc, 32'h0);

`ifdef IF_SINGLE_STEP_EN
        // Three isolated step pulses give exactly three fetches.
        next_cycle(); rst = 1'b1; step_mode = 1'b1; step_pulse = 1'b0;
        next_cycle(); rst = 1'b0;
        en_cnt = 0; n = 0; last_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            step_pulse = (i == 2 || i == 6 || i == 10);
            @(negedge clk);
            if (rom_en) en_cnt++;
            if (out_valid) begin
                chk($sformatf("step head%0d pc", n), out_pc, 32'(n * 4));
                n++;
            end
            next_cycle();
        end
        step_pulse = 1'b0;
        chk("step rom_en count", 32'(en_cnt), 32'h3);
        chk("step entry count", 32'(n), 32'h3);
        step_mode = 1'b0;
`else
        n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
